// File: rtl/vector_pkg.sv
// Shared encodings and BRAM geometry for the per-PE vector engine.
// The BRAM instance and the engine both take their sizes from here.
package vector_pkg;

  localparam int VEC_DEPTH  = 160;
  localparam int VEC_DATA_W = 16;
  localparam int VEC_ADDR_W = 10;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_MAX = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/vector_alu.sv
// Element-wise unsigned ALU: add, sub, low half of the product, max.
// Purely combinational so both BRAM write paths can share it.
module vector_alu
  import vector_pkg::*;
#(
  parameter int DATA_W = VEC_DATA_W
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic [2*DATA_W-1:0] product;

  assign product = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  always_comb begin
    result = a;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = product[DATA_W-1:0];
      OP_MAX:  result = (b > a) ? b : a;  // tie keeps a
      default: result = a;
    endcase
  end

endmodule

// File: rtl/bram_vector_engine.sv
// Per-PE vector execution stage: reads two operand vectors from a dual-port
// BRAM one element at a time and writes the element-wise result via port A.
module bram_vector_engine
  import vector_pkg::*;
#(
  parameter int SIZE   = 5,
  parameter int ADDR_W = VEC_ADDR_W,
  parameter int DATA_W = VEC_DATA_W,
  parameter int DEPTH  = VEC_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SIZE-1:0]   my_id,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SIZE-1:0]   cmd_id,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic              bram_wea,
  output logic              bram_web,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic [DATA_W-1:0] bram_dia,
  output logic [DATA_W-1:0] bram_dib,
  input  logic [DATA_W-1:0] bram_doa,
  input  logic [DATA_W-1:0] bram_dob,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e            state_reg;
  op_e               op_reg;
  logic [ADDR_W-1:0] src_a_reg;
  logic [ADDR_W-1:0] src_b_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [ADDR_W-1:0] len_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [DATA_W-1:0] result_reg;
  logic [ADDR_W-1:0] addra_reg;
  logic [ADDR_W-1:0] addrb_reg;
  logic              wea_reg;
  logic              done_reg;
  logic              err_reg;

  logic [DATA_W-1:0] alu_result;
  logic [ADDR_W:0]   end_a;
  logic [ADDR_W:0]   end_b;
  logic [ADDR_W:0]   end_d;
  logic              range_bad;
  logic [ADDR_W-1:0] idx_next;
  logic              last_elem;

  vector_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_reg),
    .a      (bram_doa),
    .b      (bram_dob),
    .result (alu_result)
  );

  // One extra bit so base+len cannot wrap past the top of the address space.
  assign end_a     = {1'b0, cmd_src_a} + {1'b0, cmd_len};
  assign end_b     = {1'b0, cmd_src_b} + {1'b0, cmd_len};
  assign end_d     = {1'b0, cmd_dst}   + {1'b0, cmd_len};
  assign range_bad = (end_a > DEPTH_L) || (end_b > DEPTH_L) || (end_d > DEPTH_L);

  assign idx_next  = idx_reg + 1'b1;
  assign last_elem = (idx_next == len_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      op_reg     <= OP_ADD;
      src_a_reg  <= '0;
      src_b_reg  <= '0;
      dst_reg    <= '0;
      len_reg    <= '0;
      idx_reg    <= '0;
      result_reg <= '0;
      addra_reg  <= '0;
      addrb_reg  <= '0;
      wea_reg    <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid && (cmd_id == my_id)) begin
            op_reg    <= op_e'(cmd_op);
            src_a_reg <= cmd_src_a;
            src_b_reg <= cmd_src_b;
            dst_reg   <= cmd_dst;
            len_reg   <= cmd_len;
            idx_reg   <= '0;
            if (cmd_len == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else if (range_bad) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
            end else begin
              state_reg <= ST_READ;
              addra_reg <= cmd_src_a;
              addrb_reg <= cmd_src_b;
            end
          end
        end

        ST_READ: begin
          addra_reg <= '0;
          addrb_reg <= '0;
          state_reg <= ST_CAPT;
        end

        // Read data is valid now; the result drives port A write data directly.
        ST_CAPT: begin
          result_reg <= alu_result;
          addra_reg  <= dst_reg + idx_reg;
          wea_reg    <= 1'b1;
          state_reg  <= ST_WRITE;
        end

        ST_WRITE: begin
          wea_reg    <= 1'b0;
          result_reg <= '0;
          if (last_elem) begin
            addra_reg <= '0;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            idx_reg   <= idx_next;
            addra_reg <= src_a_reg + idx_next;
            addrb_reg <= src_b_reg + idx_next;
            state_reg <= ST_READ;
          end
        end

        ST_DONE: begin
          done_reg  <= 1'b0;
          err_reg   <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_reg == ST_IDLE);
  assign busy       = (state_reg != ST_IDLE);
  assign done       = done_reg;
  assign err        = err_reg;
  assign bram_wea   = wea_reg;
  assign bram_addra = addra_reg;
  assign bram_addrb = addrb_reg;
  assign bram_dia   = result_reg;
  assign bram_web   = 1'b0;
  assign bram_dib   = '0;

endmodule

// File: doc/bram_vector_engine.md
Name: bram_vector_engine

Overview:
- Per-PE execution stage that sits directly upstream of the 160x16 dual-port BRAM.
- Accepts one vector command and reads two operand vectors through BRAM ports A and B. It computes an element-wise result and writes it back through port A.
- Processes one element at a time and is not overlapped, so source and destination ranges may alias safely.
- Signals completion to the subsystem sequencer with a one-cycle done pulse.

Parameters:
- SIZE, default 5, width of PE id and of cmd_id.
- ADDR_W, default 10, BRAM address width.
- DATA_W, default 16, BRAM data width.
- DEPTH, default 160, number of valid BRAM words; addresses 0..DEPTH-1.

Ports:
- clk  in  1  sole clock.
- reset  in  1  one clock; reset is asynchronous and active-low.
- my_id  in  SIZE  this PE's id.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_id  in  SIZE  target PE.
- cmd_op  in  2  00 add, 01 sub, 10 mul, 11 max.
- cmd_src_a  in  ADDR_W  operand A base.
- cmd_src_b  in  ADDR_W  operand B base.
- cmd_dst  in  ADDR_W  result base.
- cmd_len  in  ADDR_W  element count.
- bram_wea  out  1  port A write enable.
- bram_web  out  1  port B write enable; constant 0.
- bram_addra  out  ADDR_W  port A address.
- bram_addrb  out  ADDR_W  port B address.
- bram_dia  out  DATA_W  port A write data.
- bram_dib  out  DATA_W  port B write data; constant 0.
- bram_doa  in  DATA_W  port A read data; registered, valid the cycle after the address is presented.
- bram_dob  in  DATA_W  port B read data; same timing as bram_doa.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse alongside done when the command was rejected for range.

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE.
  - Element index, latched command and result register are cleared.
  - All BRAM outputs are 0; busy=0, done=0, err=0. cmd_ready goes to 1 after reset releases.
  - Reset during an operation aborts immediately; elements already written stay in BRAM.
- Handshake: a command is accepted on a clk edge with cmd_valid & cmd_ready. The command is latched at that edge.
  - cmd_id != my_id: the command is consumed and dropped; stay IDLE with no pulse.
  - cmd_len == 0: go to DONE; done=1, err=0, no BRAM access.
  - Range check uses ADDR_W+1-bit sums. If any of src_a+len, src_b+len or dst+len exceeds DEPTH, go to DONE with done=1, err=1 and no BRAM access.
  - Otherwise: i=0, go to READ.
- State machine, three cycles per element:
  - IDLE: waits for a command as above.
  - READ: addra=src_a+i, addrb=src_b+i, wea=0. Go to CAPT.
  - CAPT: doa/dob are valid. result <= op(doa, dob). Go to WRITE.
  - WRITE: addra=dst+i, dia=result, wea=1 for exactly this cycle. If i==len-1, go to DONE; else i<=i+1 and go to READ.
  - DONE: done=1 (err as determined at accept). Go to IDLE; cmd_ready=1 the following cycle.
- Outputs outside READ/WRITE: addresses and dia=0, wea=0.
- Arithmetic (all unsigned, results truncated to DATA_W):
  - add: a+b mod 2^16.
  - sub: a-b mod 2^16.
  - mul: low 16 bits of the 32-bit product.
  - max: larger of a and b; on a tie, a.
- Latency: accept edge to done pulse = 3*len+1 cycles. len=0 and range error take 1 cycle (done in the cycle after accept).
- Port A never reads and writes in the same cycle, so BRAM write-first semantics are irrelevant. Aliased dst==src_a is well defined: element i is read before it is written.
- cmd inputs are ignored while busy; the latched copy is used throughout.

Decomposition:
- Shared package (vector_pkg):
  - op encodings OP_ADD/OP_SUB/OP_MUL/OP_MAX.
  - state encoding IDLE/READ/CAPT/WRITE/DONE.
  - DEPTH and DATA_W/ADDR_W constants shared with the BRAM instance.
- One sub-module is natural: vector_alu. It is purely combinational, with inputs op, a, b and output result. It is reused later by the port-B write path.
- FSM, index counter and range check stay in bram_vector_engine.

Test Plan:
- Reset release → cmd_ready=1, busy=0, all BRAM outputs 0. Reset asserted mid-WRITE → wea=0 asynchronously; state IDLE.
- my_id=3, preload A[0..3]={1,2,3,0xFFFF} at 0, B={10,20,30,2} at 16; cmd add, dst 32, len 4 → mem[32..35]={11,22,33,1}; done exactly 13 cycles after accept; wea high exactly 4 cycles.
- Ops on a=0x0003, b=0x0005, len 1: sub → 0xFFFE; mul 0x1234*0x0100 → 0x3400; max(7,7) → 7.
- Alias: dst=src_a=0, src_b=0, len 3, data {1,2,3}, add → {2,4,6}.
- Range: src_a=150, len 11 → done=1, err=1 one cycle after accept, zero BRAM writes. len=0 → done=1, err=0.
- cmd_id=4 with my_id=3 → accepted with no done and no BRAM activity. A command while busy is not accepted (cmd_ready=0) and does not alter the in-flight operation.
